// File: rtl/sram_ctrl_pkg.sv
// Shared types and sizing helpers for the multi-port SRAM controller.
package sram_ctrl_pkg;

  // Access engine states: IDLE waits for a request, ACCESS holds the pins,
  // TURN gives the data bus one dead cycle after a write.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    TURN   = 2'd2
  } state_e;

  // Number of byte lanes for a given data width.
  function automatic int be_bits(input int data_bits);
    return data_bits / 8;
  endfunction

  // Register width able to hold values 0..max_val (never less than 1 bit).
  function automatic int width_for(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sram_rr_arbiter.sv
// Request arbiter for the SRAM controller.
// Build option SRAM_CTRL_RR_EN: defined -> round-robin starting at i_ptr,
// undefined -> fixed priority (lowest index wins) with no pointer ports.
module sram_rr_arbiter
  import sram_ctrl_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int PTR_BITS  = width_for(NUM_PORTS - 1)
) (
  input  logic [NUM_PORTS-1:0] i_req,
`ifdef SRAM_CTRL_RR_EN
  input  logic [PTR_BITS-1:0]  i_ptr,
  output logic [PTR_BITS-1:0]  o_next_ptr,
`endif
  output logic [NUM_PORTS-1:0] o_gnt,
  output logic [PTR_BITS-1:0]  o_idx
);

  logic                w_found;
  logic [PTR_BITS-1:0] w_cand;

`ifdef SRAM_CTRL_RR_EN
  // Scan ports starting at the pointer; first requester wins, pointer moves past it.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_cand = PTR_BITS'((int'(i_ptr) + i) % NUM_PORTS);
      if (!w_found && i_req[w_cand]) begin
        w_found       = 1'b1;
        o_gnt[w_cand] = 1'b1;
        o_idx         = w_cand;
      end
    end
    o_next_ptr = PTR_BITS'((int'(o_idx) + 1) % NUM_PORTS);
  end
`else
  // Fixed priority encoder: lowest requesting index wins.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_cand = PTR_BITS'(i);
      if (!w_found && i_req[w_cand]) begin
        w_found       = 1'b1;
        o_gnt[w_cand] = 1'b1;
        o_idx         = w_cand;
      end
    end
  end
`endif

endmodule

// File: rtl/sram_mp_ctrl.sv
// Multi-port sequenced controller for an external asynchronous SRAM.
// All SRAM pins and the DQ output enable come from registers.
// Build option SRAM_CTRL_RR_EN selects round-robin arbitration (default: fixed priority).
module sram_mp_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_BITS   = 16,
  parameter int ADDR_BITS   = 20,
  parameter int NUM_PORTS   = 2,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic [NUM_PORTS-1:0]                   req,
  input  logic [NUM_PORTS-1:0]                   we,
  input  logic [NUM_PORTS*ADDR_BITS-1:0]         addr,
  input  logic [NUM_PORTS*DATA_BITS-1:0]         wdata,
  input  logic [NUM_PORTS*be_bits(DATA_BITS)-1:0] be_n,
  output logic [NUM_PORTS-1:0]                   gnt,
  output logic [NUM_PORTS-1:0]                   rvalid,
  output logic [DATA_BITS-1:0]                   rdata,
  output logic                                   busy,
  output logic [ADDR_BITS-1:0]                   SRAM_ADDR,
  inout  wire  [DATA_BITS-1:0]                   SRAM_DQ,
  output logic [be_bits(DATA_BITS)-1:0]          SRAM_BE_n,
  output logic                                   SRAM_CE_n,
  output logic                                   SRAM_OE_n,
  output logic                                   SRAM_WE_n
);

  localparam int BE_BITS  = be_bits(DATA_BITS);
  localparam int PTR_BITS = width_for(NUM_PORTS - 1);
  localparam int CNT_BITS = width_for(WAIT_CYCLES);

  state_e                 r_state;
  state_e                 w_state_nx;
  logic                   w_start;
  logic [CNT_BITS-1:0]    r_cnt;
  logic                   r_we;
  logic [PTR_BITS-1:0]    r_port;
  logic                   r_dq_oe;
  logic [DATA_BITS-1:0]   r_dq_out;
  logic [NUM_PORTS-1:0]   w_arb_gnt;
  logic [PTR_BITS-1:0]    w_arb_idx;

`ifdef SRAM_CTRL_RR_EN
  logic [PTR_BITS-1:0]    r_ptr;
  logic [PTR_BITS-1:0]    w_next_ptr;

  // Round-robin pointer advances past the port granted at each acceptance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_ptr <= '0;
    else if (w_start) r_ptr <= w_next_ptr;
  end

  sram_rr_arbiter #(.NUM_PORTS(NUM_PORTS), .PTR_BITS(PTR_BITS)) u_arb (
    .i_req      (req),
    .i_ptr      (r_ptr),
    .o_next_ptr (w_next_ptr),
    .o_gnt      (w_arb_gnt),
    .o_idx      (w_arb_idx)
  );
`else
  sram_rr_arbiter #(.NUM_PORTS(NUM_PORTS), .PTR_BITS(PTR_BITS)) u_arb (
    .i_req (req),
    .o_gnt (w_arb_gnt),
    .o_idx (w_arb_idx)
  );
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nx;
  end

  // Next-state logic; w_start marks an accepted request on the IDLE edge.
  always_comb begin
    w_state_nx = r_state;
    w_start    = 1'b0;
    case (r_state)
      IDLE: begin
        if (|req) begin
          w_state_nx = ACCESS;
          w_start    = 1'b1;
        end
      end
      ACCESS:  if (r_cnt == '0) w_state_nx = r_we ? TURN : IDLE;
      TURN:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  // Pin, latch and response registers; pins are set up on the grant edge
  // and released on the final ACCESS edge, where read data is captured.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt       <= '0;
      rvalid    <= '0;
      rdata     <= '0;
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_port    <= '0;
      r_dq_oe   <= 1'b0;
      r_dq_out  <= '0;
      SRAM_ADDR <= '0;
      SRAM_BE_n <= '1;
      SRAM_CE_n <= 1'b1;
      SRAM_OE_n <= 1'b1;
      SRAM_WE_n <= 1'b1;
    end else begin
      gnt    <= '0;
      rvalid <= '0;
      if (w_start) begin
        gnt       <= w_arb_gnt;
        r_port    <= w_arb_idx;
        r_we      <= we[w_arb_idx];
        r_cnt     <= CNT_BITS'(WAIT_CYCLES);
        r_dq_out  <= wdata[w_arb_idx*DATA_BITS +: DATA_BITS];
        SRAM_ADDR <= addr[w_arb_idx*ADDR_BITS +: ADDR_BITS];
        SRAM_CE_n <= 1'b0;
        if (we[w_arb_idx]) begin
          SRAM_WE_n <= 1'b0;
          SRAM_OE_n <= 1'b1;
          SRAM_BE_n <= be_n[w_arb_idx*BE_BITS +: BE_BITS];
          r_dq_oe   <= 1'b1;
        end else begin
          SRAM_WE_n <= 1'b1;
          SRAM_OE_n <= 1'b0;
          SRAM_BE_n <= '0;
          r_dq_oe   <= 1'b0;
        end
      end else if (r_state == ACCESS) begin
        if (r_cnt != '0) begin
          r_cnt <= r_cnt - 1'b1;
        end else begin
          SRAM_CE_n <= 1'b1;
          SRAM_WE_n <= 1'b1;
          SRAM_OE_n <= 1'b1;
          SRAM_BE_n <= '1;
          r_dq_oe   <= 1'b0;
          if (!r_we) begin
            rdata          <= SRAM_DQ;
            rvalid[r_port] <= 1'b1;
          end
        end
      end
    end
  end

  assign SRAM_DQ = r_dq_oe ? r_dq_out : {DATA_BITS{1'bz}};
  assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_sram_mp_ctrl.sv
// Self-checking bench for sram_mp_ctrl: behavioural SRAM, reference memory,
// read-response scoreboard and per-access pin timing checks.
module tb_sram_mp_ctrl;

  localparam int DW   = 16;
  localparam int AW   = 20;
  localparam int NP   = 2;
  localparam int WAIT = 1;
  localparam int BEB  = DW / 8;

  logic               clk;
  logic               reset_n;
  logic [NP-1:0]      req, we;
  logic [NP*AW-1:0]   addr;
  logic [NP*DW-1:0]   wdata;
  logic [NP*BEB-1:0]  be_n;
  logic [NP-1:0]      gnt, rvalid;
  logic [DW-1:0]      rdata;
  logic               busy;
  logic [AW-1:0]      sram_addr;
  wire  [DW-1:0]      sram_dq;
  logic [BEB-1:0]     sram_be_n;
  logic               sram_ce_n, sram_oe_n, sram_we_n;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int rr_next;

  typedef struct {int port; logic [DW-1:0] data;} exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  logic [DW-1:0] sram_mem [1024];
  logic [DW-1:0] ref_mem  [1024];
  logic          probe_en;
  logic [DW-1:0] probe_val;

  sram_mp_ctrl #(.DATA_BITS(DW), .ADDR_BITS(AW), .NUM_PORTS(NP), .WAIT_CYCLES(WAIT)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .be_n(be_n), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy),
    .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq), .SRAM_BE_n(sram_be_n),
    .SRAM_CE_n(sram_ce_n), .SRAM_OE_n(sram_oe_n), .SRAM_WE_n(sram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Asynchronous SRAM model; the probe drives a known value to show the DUT has released DQ.
  wire sram_rd = !sram_ce_n && !sram_oe_n && sram_we_n;
  assign sram_dq = probe_en ? probe_val : (sram_rd ? sram_mem[sram_addr[9:0]] : {DW{1'bz}});
  always @(negedge clk)
    if (!sram_ce_n && !sram_we_n)
      for (int b = 0; b < BEB; b++)
        if (!sram_be_n[b]) sram_mem[sram_addr[9:0]][b*8 +: 8] <= sram_dq[b*8 +: 8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every rvalid pulse must match the oldest expected read.
  always @(negedge clk) begin
    if (rvalid != '0) begin
      if (exp_q.size() == 0) begin
        check("rvalid_unexpected", 32'(rvalid), 32'h0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rvalid_port", 32'(rvalid), 32'h1 << mon_e.port);
        check("rdata", 32'(rdata), 32'(mon_e.data));
      end
    end
  end

  task automatic next_cycle(input int p);
    @(posedge clk); #1;
    req[p] = 1'b0;
    @(negedge clk);
  endtask

  // One request on port p while the controller is idle, with pin timing checks.
  task automatic access(input int p, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [BEB-1:0] b);
    int  k;
    bit  got;
    @(posedge clk); #1;
    req[p] = 1'b1; we[p] = w;
    addr[p*AW +: AW] = a; wdata[p*DW +: DW] = d; be_n[p*BEB +: BEB] = b;
    k = 0; got = 0;
    while (!got && k < 20) begin
      @(negedge clk); k++;
      if (gnt[p]) got = 1;
    end
    if (!got) begin
      check("gnt_timeout", 32'h0, 32'h1);
      req[p] = 1'b0;
      return;
    end
    check("gnt_latency", k, 2);
    check("gnt_onehot", 32'(gnt), 32'h1 << p);
    if (w) begin
      for (int bb = 0; bb < BEB; bb++)
        if (!b[bb]) ref_mem[a[9:0]][bb*8 +: 8] = d[bb*8 +: 8];
    end else begin
      exp_q.push_back(exp_t'{port: p, data: ref_mem[a[9:0]]});
    end
    rr_next = (p + 1) % NP;
    for (int c = 1; c <= WAIT + 1; c++) begin
      if (c > 1) next_cycle(p);
      check("acc_ce_n", 32'(sram_ce_n), 32'h0);
      check("acc_we_n", 32'(sram_we_n), 32'(!w));
      check("acc_oe_n", 32'(sram_oe_n), 32'(w));
      check("acc_addr", 32'(sram_addr), 32'(a));
      check("acc_be_n", 32'(sram_be_n), w ? 32'(b) : 32'h0);
      check("acc_busy", 32'(busy), 32'h1);
      if (w) check("acc_dq", 32'(sram_dq), 32'(d));
    end
    next_cycle(p);
    if (w) begin
      check("turn_ctl", {29'h0, sram_ce_n, sram_we_n, sram_oe_n}, 32'h7);
      check("turn_addr", 32'(sram_addr), 32'(a));
      check("turn_busy", 32'(busy), 32'h1);
      check("turn_rvalid", 32'(rvalid), 32'h0);
      next_cycle(p);
      check("wr_idle_busy", 32'(busy), 32'h0);
    end else begin
      check("rd_rvalid_time", 32'(rvalid[p]), 32'h1);
      check("rd_idle_busy", 32'(busy), 32'h0);
      check("rd_idle_ce_n", 32'(sram_ce_n), 32'h1);
    end
  endtask

  // Both ports hold read requests; checks grant order and back-to-back period.
  task automatic contention(input int n_grants);
    int seen, k, exp_p, last_cyc;
    @(posedge clk); #1;
    req = '1; we = '0;
    addr[0 +: AW] = 20'h00010; addr[AW +: AW] = 20'h00020;
    seen = 0; k = 0; last_cyc = 0;
    while (seen < n_grants && k < 200) begin
      @(negedge clk); k++;
      if (gnt != '0) begin
`ifdef SRAM_CTRL_RR_EN
        exp_p = rr_next;
`else
        exp_p = 0;
`endif
        check("arb_order", 32'(gnt), 32'h1 << exp_p);
        if (seen > 0) check("b2b_period", cyc - last_cyc, WAIT + 2);
        last_cyc = cyc;
        exp_q.push_back(exp_t'{port: exp_p, data: ref_mem[(exp_p != 0) ? 10'h020 : 10'h010]});
        rr_next = (exp_p + 1) % NP;
        seen++;
      end
    end
    check("arb_grants_seen", seen, n_grants);
    @(posedge clk); #1;
    req = '0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    for (int i = 0; i < 1024; i++) begin
      sram_mem[i] = '0;
      ref_mem[i]  = '0;
    end
    req = '0; we = '0; addr = '0; wdata = '0; be_n = '1;
    probe_en = 1'b0; probe_val = 16'h00FF;
    reset_n = 1'b0;
    rr_next = 0;

    // Reset state, with the probe confirming DQ is not driven.
    #22;
    probe_en = 1'b1;
    #1;
    check("rst_ce_n", 32'(sram_ce_n), 32'h1);
    check("rst_oe_n", 32'(sram_oe_n), 32'h1);
    check("rst_we_n", 32'(sram_we_n), 32'h1);
    check("rst_be_n", 32'(sram_be_n), 32'h3);
    check("rst_addr", 32'(sram_addr), 32'h0);
    check("rst_gnt_rvalid", {28'h0, gnt, rvalid}, 32'h0);
    check("rst_rdata", 32'(rdata), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_dq_released", 32'(sram_dq), 32'h00FF);
    probe_en = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // Directed write/read and byte-enable merge.
    access(0, 1'b1, 20'h00010, 16'hBEEF, 2'b00);
    access(0, 1'b0, 20'h00010, 16'h0000, 2'b11);
    access(0, 1'b1, 20'h00010, 16'h1234, 2'b10);
    access(0, 1'b0, 20'h00010, 16'h0000, 2'b11);
    access(1, 1'b1, 20'h00020, 16'hC0DE, 2'b00);
    access(1, 1'b1, 20'h00020, 16'h55AA, 2'b01);
    access(1, 1'b0, 20'h00020, 16'h0000, 2'b11);

    // Continuous requests on both ports.
    contention(6);

    // Randomized mixed traffic; low index bits confined to a small window for reuse.
    for (int n = 0; n < 40; n++) begin
      access($urandom_range(0, NP - 1), 1'($urandom_range(0, 1)),
             AW'($urandom()) & 20'hFFC0F, DW'($urandom()), BEB'($urandom_range(0, 3)));
    end

    // Reset in the middle of a write ACCESS.
    @(posedge clk); #1;
    req[0] = 1'b1; we[0] = 1'b1;
    addr[0 +: AW] = 20'h003FF; wdata[0 +: DW] = 16'hF0F0; be_n[0 +: BEB] = 2'b00;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (gnt[0]) got = 1;
    end
    check("mid_rst_gnt_seen", 32'(got), 32'h1);
    #2 reset_n = 1'b0;
    probe_en = 1'b1;
    #1;
    check("mid_rst_ctl", {29'h0, sram_ce_n, sram_we_n, sram_oe_n}, 32'h7);
    check("mid_rst_dq_released", 32'(sram_dq), 32'h00FF);
    check("mid_rst_gnt_rvalid", {28'h0, gnt, rvalid}, 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    probe_en = 1'b0;
    req = '0;
    rr_next = 0;
    @(negedge clk);
    check("mid_rst_hold", {27'h0, gnt, rvalid, busy}, 32'h0);
    reset_n = 1'b1;
    access(1, 1'b0, 20'h00010, 16'h0000, 2'b11);
    access(0, 1'b0, 20'h00020, 16'h0000, 2'b11);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
